block_stats_responder: RTL and testbench

- Responder end of the noise-estimation block handshake; owns the arithmetic side the controller sequences.
- Accepts one block of TOTAL_SAMPLES pixels and returns the block mean with a level `mean_ready`.
- After `variance_start_of_data`, accepts the same block again and returns the population variance with a one-cycle `variance_ready` pulse.
- Sits between the block shift register and the noise-mean accumulator; one instance per colour channel.

---
 rtl/noise_est_pkg.sv | 19 +
 rtl/block_stats_responder_if.sv | 25 ++
 rtl/block_stats_responder_sq_diff.sv | 22 ++
 rtl/block_stats_responder.sv | 141 ++++++++++++++
 tb/tb_block_stats_responder.sv | 166 ++++++++++++++++
 5 files changed

// File: rtl/noise_est_pkg.sv
// Shared types and width helpers for the noise-estimation datapath.
package noise_est_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MEAN_ACC,
        ST_MEAN_HOLD,
        ST_VAR_ACC
    } stats_state_t;

    function automatic int unsigned sum_w(input int unsigned data_w, input int unsigned log2_n);
        return data_w + log2_n;
    endfunction

    function automatic int unsigned var_acc_w(input int unsigned data_w, input int unsigned log2_n);
        return 2 * data_w + log2_n;
    endfunction

endpackage

// File: rtl/block_stats_responder_if.sv
// Handshake between the block controller (master) and the stats responder (slave).
interface block_stats_responder_if #(
    parameter int unsigned DATA_WIDTH = 8
);
    logic                    frame_restart;
    logic                    data_valid;
    logic [DATA_WIDTH-1:0]   data_in;
    logic                    variance_start_of_data;
    logic [DATA_WIDTH-1:0]   mean_out;
    logic                    mean_ready;
    logic [2*DATA_WIDTH-1:0] variance_out;
    logic                    variance_ready;
    logic                    busy;
    logic                    sample_drop;

    modport master (
        output frame_restart, data_valid, data_in, variance_start_of_data,
        input  mean_out, mean_ready, variance_out, variance_ready, busy, sample_drop
    );

    modport slave (
        input  frame_restart, data_valid, data_in, variance_start_of_data,
        output mean_out, mean_ready, variance_out, variance_ready, busy, sample_drop
    );
endinterface

// File: rtl/block_stats_responder_sq_diff.sv
// Combinational squared difference of two unsigned values.
module sq_diff #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0]   a,
    input  logic [DATA_WIDTH-1:0]   b,
    output logic [2*DATA_WIDTH-1:0] sq
);
    logic signed [DATA_WIDTH:0]   diff;
    logic        [DATA_WIDTH:0]   neg;
    logic        [DATA_WIDTH-1:0] mag;
    logic        [2*DATA_WIDTH-1:0] mag_ext;

    // |a-b| always fits DATA_WIDTH bits, so square the magnitude unsigned
    always_comb begin
        diff    = $signed({1'b0, a}) - $signed({1'b0, b});
        neg     = -diff;
        mag     = diff[DATA_WIDTH] ? neg[DATA_WIDTH-1:0] : diff[DATA_WIDTH-1:0];
        mag_ext = {{DATA_WIDTH{1'b0}}, mag};
        sq      = mag_ext * mag_ext;
    end
endmodule

// File: rtl/block_stats_responder.sv
// Two-pass block statistics: mean on the first pass, population variance on the second.
module block_stats_responder
    import noise_est_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = 8,
    parameter int unsigned TOTAL_SAMPLES = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    block_stats_responder_if.slave bus
);
    localparam int unsigned LOG2_SAMPLES = $clog2(TOTAL_SAMPLES);
    localparam int unsigned SUM_W        = sum_w(DATA_WIDTH, LOG2_SAMPLES);
    localparam int unsigned VAR_W        = var_acc_w(DATA_WIDTH, LOG2_SAMPLES);
    localparam int unsigned CNT_W        = LOG2_SAMPLES + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TOTAL_SAMPLES);

    generate
        if ((1 << LOG2_SAMPLES) != TOTAL_SAMPLES) begin : g_bad_samples
            $error("TOTAL_SAMPLES must be a power of 2");
        end
    endgenerate

    stats_state_t            state_q, state_d;
    logic [SUM_W-1:0]        sum_q, sum_d, sum_base;
    logic [VAR_W-1:0]        var_acc_q, var_acc_d, var_base;
    logic [CNT_W-1:0]        count_q, count_d, cnt_inc;
    logic [DATA_WIDTH-1:0]   mean_out_q, mean_out_d;
    logic [2*DATA_WIDTH-1:0] variance_out_q, variance_out_d;
    logic                    mean_ready_q, mean_ready_d;
    logic                    variance_ready_q, variance_ready_d;
    logic                    sample_drop_q, sample_drop_d;
    logic [2*DATA_WIDTH-1:0] sq;
    logic                    last, var_accept;

    sq_diff #(.DATA_WIDTH(DATA_WIDTH)) u_sq_diff (
        .a  (bus.data_in),
        .b  (mean_out_q),
        .sq (sq)
    );

    always_comb begin
        state_d          = state_q;
        sum_d            = sum_q;
        var_acc_d        = var_acc_q;
        count_d          = count_q;
        mean_out_d       = mean_out_q;
        variance_out_d   = variance_out_q;
        variance_ready_d = 1'b0;
        sample_drop_d    = 1'b0;
        cnt_inc          = count_q + CNT_W'(1);
        last             = (cnt_inc == CNT_LAST);
        sum_base         = (state_q == ST_MEAN_ACC) ? sum_q : '0;
        var_base         = (state_q == ST_VAR_ACC) ? var_acc_q : '0;
        var_accept       = bus.data_valid &&
                           ((state_q == ST_VAR_ACC) ||
                            (state_q == ST_MEAN_HOLD && bus.variance_start_of_data));

        // count is zero on entry to every pass, so IDLE and MEAN_HOLD share the accumulate paths
        case (state_q)
            ST_IDLE, ST_MEAN_ACC: begin
                if (bus.data_valid) begin
                    sum_d   = sum_base + SUM_W'(bus.data_in);
                    count_d = cnt_inc;
                    state_d = ST_MEAN_ACC;
                    if (last) begin
                        mean_out_d = sum_d[LOG2_SAMPLES +: DATA_WIDTH];
                        count_d    = '0;
                        state_d    = ST_MEAN_HOLD;
                    end
                end
            end
            ST_MEAN_HOLD: begin
                if (bus.variance_start_of_data) begin
                    var_acc_d = '0;
                    count_d   = '0;
                    state_d   = ST_VAR_ACC;
                end else if (bus.data_valid) begin
                    sample_drop_d = 1'b1;
                end
            end
            ST_VAR_ACC: ;
            default: state_d = ST_IDLE;
        endcase

        if (var_accept) begin
            var_acc_d = var_base + VAR_W'(sq);
            count_d   = cnt_inc;
            if (last) begin
                variance_out_d   = var_acc_d[LOG2_SAMPLES +: 2*DATA_WIDTH];
                variance_ready_d = 1'b1;
                count_d          = '0;
                state_d          = ST_IDLE;
            end
        end

        if (bus.frame_restart) begin
            state_d          = ST_IDLE;
            sum_d            = '0;
            var_acc_d        = '0;
            count_d          = '0;
            mean_out_d       = mean_out_q;
            variance_out_d   = variance_out_q;
            variance_ready_d = 1'b0;
            sample_drop_d    = 1'b0;
        end

        mean_ready_d = (state_d == ST_MEAN_HOLD);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= ST_IDLE;
            sum_q            <= '0;
            var_acc_q        <= '0;
            count_q          <= '0;
            mean_out_q       <= '0;
            variance_out_q   <= '0;
            mean_ready_q     <= 1'b0;
            variance_ready_q <= 1'b0;
            sample_drop_q    <= 1'b0;
        end else begin
            state_q          <= state_d;
            sum_q            <= sum_d;
            var_acc_q        <= var_acc_d;
            count_q          <= count_d;
            mean_out_q       <= mean_out_d;
            variance_out_q   <= variance_out_d;
            mean_ready_q     <= mean_ready_d;
            variance_ready_q <= variance_ready_d;
            sample_drop_q    <= sample_drop_d;
        end
    end

    assign bus.mean_out       = mean_out_q;
    assign bus.mean_ready     = mean_ready_q;
    assign bus.variance_out   = variance_out_q;
    assign bus.variance_ready = variance_ready_q;
    assign bus.sample_drop    = sample_drop_q;
    assign bus.busy           = (state_q != ST_IDLE);
endmodule

// File: tb/tb_block_stats_responder.sv
// Directed bench for block_stats_responder with hand-computed mean/variance results.
module tb_block_stats_responder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int unsigned checks   = 0;
    int unsigned failures = 0;
    logic [7:0] blk [64];

    block_stats_responder_if #(.DATA_WIDTH(8)) bus ();

    block_stats_responder #(
        .DATA_WIDTH    (8),
        .TOTAL_SAMPLES (64)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input logic dv, input logic [7:0] d, input logic vs, input logic fr);
        bus.data_valid             = dv;
        bus.data_in                = d;
        bus.variance_start_of_data = vs;
        bus.frame_restart          = fr;
        @(posedge clk);
        #1;
        bus.data_valid             = 1'b0;
        bus.data_in                = '0;
        bus.variance_start_of_data = 1'b0;
        bus.frame_restart          = 1'b0;
    endtask

    task automatic gap(input bit en);
        if (en) repeat ($urandom_range(0, 2)) step(1'b0, 8'd0, 1'b0, 1'b0);
    endtask

    task automatic mean_pass(input int unsigned exp_mean, input bit gaps, input int unsigned first);
        for (int unsigned i = first; i < 64; i++) begin
            gap(gaps);
            step(1'b1, blk[i], 1'b0, 1'b0);
            if (i == 62) check_eq("mean_ready_early", bus.mean_ready, 0);
        end
        check_eq("mean_ready", bus.mean_ready, 1);
        check_eq("mean_out", bus.mean_out, exp_mean);
    endtask

    task automatic var_pass(input int unsigned exp_var, input bit gaps, input bit combined);
        int unsigned first;
        if (combined) begin
            step(1'b1, blk[0], 1'b1, 1'b0);
            first = 1;
        end else begin
            step(1'b0, 8'd0, 1'b1, 1'b0);
            first = 0;
        end
        check_eq("mean_ready_drop", bus.mean_ready, 0);
        for (int unsigned i = first; i < 64; i++) begin
            gap(gaps);
            step(1'b1, blk[i], 1'b0, 1'b0);
            if (i == 62) check_eq("var_ready_early", bus.variance_ready, 0);
        end
        check_eq("var_ready", bus.variance_ready, 1);
        check_eq("var_out", bus.variance_out, exp_var);
    endtask

    initial begin
        bus.data_valid             = 1'b0;
        bus.data_in                = '0;
        bus.variance_start_of_data = 1'b0;
        bus.frame_restart          = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_mean_out", bus.mean_out, 0);
        check_eq("rst_mean_ready", bus.mean_ready, 0);
        check_eq("rst_var_out", bus.variance_out, 0);
        check_eq("rst_var_ready", bus.variance_ready, 0);
        check_eq("rst_busy", bus.busy, 0);
        check_eq("rst_drop", bus.sample_drop, 0);
        rst = 1'b0;
        step(1'b0, 8'd0, 1'b1, 1'b0);
        check_eq("vsod_in_idle", bus.busy, 0);

        // constant block
        for (int i = 0; i < 64; i++) blk[i] = 8'd100;
        mean_pass(100, 1'b0, 0);
        var_pass(0, 1'b0, 1'b0);
        step(1'b0, 8'd0, 1'b0, 1'b0);
        check_eq("var_ready_pulse", bus.variance_ready, 0);
        check_eq("idle_busy", bus.busy, 0);

        // alternating 0/200, with dropped samples while holding the mean
        for (int i = 0; i < 64; i++) blk[i] = (i % 2 == 0) ? 8'd0 : 8'd200;
        mean_pass(100, 1'b0, 0);
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 8'd255, 1'b0, 1'b0);
            check_eq("drop_pulse", bus.sample_drop, 1);
            check_eq("drop_mean_hold", bus.mean_out, 100);
        end
        step(1'b0, 8'd0, 1'b0, 1'b0);
        check_eq("drop_clear", bus.sample_drop, 0);
        check_eq("hold_ready", bus.mean_ready, 1);
        var_pass(10000, 1'b0, 1'b0);
        step(1'b0, 8'd0, 1'b0, 1'b0);
        check_eq("alt_var_pulse", bus.variance_ready, 0);

        // ramp with gaps, vsod coincident with first sample, next block starts in ready cycle
        for (int i = 0; i < 64; i++) blk[i] = 8'(i);
        mean_pass(31, 1'b1, 0);
        var_pass(341, 1'b1, 1'b1);
        for (int i = 0; i < 64; i++) blk[i] = 8'd100;
        step(1'b1, 8'd100, 1'b0, 1'b0);
        check_eq("b2b_var_pulse", bus.variance_ready, 0);
        check_eq("b2b_busy", bus.busy, 1);
        mean_pass(100, 1'b0, 1);

        // frame_restart at variance sample 30
        step(1'b0, 8'd0, 1'b1, 1'b0);
        for (int i = 0; i < 30; i++) step(1'b1, 8'd100, 1'b0, 1'b0);
        step(1'b1, 8'd100, 1'b1, 1'b1);
        check_eq("fr_busy", bus.busy, 0);
        check_eq("fr_mean_ready", bus.mean_ready, 0);
        check_eq("fr_var_ready", bus.variance_ready, 0);
        check_eq("fr_var_keep", bus.variance_out, 341);
        check_eq("fr_mean_keep", bus.mean_out, 100);
        for (int i = 0; i < 40; i++) begin
            step(1'b0, 8'd0, 1'b0, 1'b0);
            check_eq("fr_no_pulse", bus.variance_ready, 0);
        end

        // async reset at mean sample 10
        for (int i = 0; i < 10; i++) step(1'b1, 8'd77, 1'b0, 1'b0);
        check_eq("pre_rst_busy", bus.busy, 1);
        rst = 1'b1;
        #2;
        check_eq("rst_mid_busy", bus.busy, 0);
        check_eq("rst_mid_mean", bus.mean_out, 0);
        check_eq("rst_mid_var", bus.variance_out, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 64; i++) blk[i] = (i % 2 == 0) ? 8'd200 : 8'd0;
        mean_pass(100, 1'b0, 0);
        var_pass(10000, 1'b0, 1'b0);
        step(1'b0, 8'd0, 1'b0, 1'b0);
        check_eq("final_var_pulse", bus.variance_ready, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
